// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: per-cycle trace capture of the 16-bit MIPS core (PC and
// ALU result) into a first-word-fall-through FIFO of sequence-tagged records.
// Capture freezes once the core's jump-to-self halt idiom is seen so the tail
// of a program run survives until the host drains it.
//
// Stream handshake: a record transfers on every rising edge where
// trc_valid && trc_ready. trc_valid and the head data depend only on
// registered state, never on trc_ready, and hold steady until transferred.
module mips_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_en,
  input  logic          clear,
  input  logic [15:0]   pc_in,
  input  logic [15:0]   alu_in,
  output logic          trc_valid,
  input  logic          trc_ready,
  output logic [15:0]   trc_pc,
  output logic [15:0]   trc_alu,
  output logic [7:0]    trc_seq,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          halted,
  output logic [7:0]    drop_cnt
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0]  seq;
    logic [15:0] pc;
    logic [15:0] alu;
  } rec_t;

  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  rec_t        mem [DEPTH];
  rec_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count_q;
  logic [7:0]  seq_q;
  logic [7:0]  drop_q;
  logic [15:0] prev_pc;
  logic        prev_vld;
  state_t      state_q;
  state_t      state_d;

  logic        sample;
  logic        pop;
  logic        push;
  logic        drop;
  logic        repeat_hit;

  // Status flags all derive from the one count register, so they agree after every edge.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_DEPTH);
  assign count     = count_q;
  assign trc_valid = !empty;
  assign halted    = (state_q == ST_HALTED);
  assign drop_cnt  = drop_q;

  // A clear cycle discards any sample and any pop.
  assign sample     = cap_en && (state_q == ST_RUN) && !clear;
  assign pop        = trc_valid && trc_ready && !clear;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push       = sample && (!full || pop);
  assign drop       = sample && !push;
  assign repeat_hit = sample && prev_vld && (pc_in == prev_pc);

  // Head record, zeroed when nothing is queued.
  assign head    = mem[rd_ptr];
  assign trc_pc  = trc_valid ? head.pc  : 16'h0000;
  assign trc_alu = trc_valid ? head.alu : 16'h0000;
  assign trc_seq = trc_valid ? head.seq : 8'h00;

  // Next state: clear re-arms, a repeated PC freezes capture.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_RUN;
    end else if (repeat_hit) begin
      state_d = ST_HALTED;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Record storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {seq_q, pc_in, alu_in};
    end
  end

  // Sequence tag advances on every sample, stored or dropped; drops saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else if (clear) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      if (sample) begin
        seq_q <= seq_q + 8'd1;
      end
      if (drop && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Previous-sample PC for halt detection; a gap in capture breaks the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
    end else if (clear || !cap_en) begin
      prev_vld <= 1'b0;
    end else if (sample) begin
      prev_pc  <= pc_in;
      prev_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: a reference model keeps the expected FIFO
// contents in a queue; records are pushed when a sample is driven and popped
// and compared when the DUT hands them out.
module tb_mips_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cap_en = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] alu_in = '0;
  logic        trc_ready = 1'b0;
  logic        trc_valid;
  logic [15:0] trc_pc;
  logic [15:0] trc_alu;
  logic [7:0]  trc_seq;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        halted;
  logic [7:0]  drop_cnt;

  mips_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .clear(clear),
    .pc_in(pc_in), .alu_in(alu_in),
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_pc(trc_pc), .trc_alu(trc_alu), .trc_seq(trc_seq),
    .count(count), .full(full), .empty(empty),
    .halted(halted), .drop_cnt(drop_cnt)
  );

  // ---------------- scoreboard / model ----------------
  logic [39:0] exp_q[$];   // {seq, pc, alu}
  logic [7:0]  m_seq;
  int          m_drop;
  bit          m_halted;
  bit          m_prev_vld;
  logic [15:0] m_prev_pc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seq      = 8'd0;
    m_drop     = 0;
    m_halted   = 1'b0;
    m_prev_vld = 1'b0;
    m_prev_pc  = '0;
  endtask

  // Compare every visible output against the model (called away from the edge).
  task automatic check_outputs();
    logic [39:0] hd;
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
    chk("valid", 32'(trc_valid), 32'(exp_q.size() != 0));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    hd = (exp_q.size() != 0) ? exp_q[0] : 40'd0;
    chk("trc_seq", 32'(trc_seq), 32'(hd[39:32]));
    chk("trc_pc", 32'(trc_pc), 32'(hd[31:16]));
    chk("trc_alu", 32'(trc_alu), 32'(hd[15:0]));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic cycle(input bit cap, input logic [15:0] pc, input logic [15:0] alu,
                       input bit rdy, input bit clr);
    bit popped;
    bit nh;
    cap_en    = cap;
    pc_in     = pc;
    alu_in    = alu;
    trc_ready = rdy;
    clear     = clr;
    @(negedge clk);
    check_outputs();
    if (clr) begin
      model_reset();
    end else begin
      nh = 1'b0;
      popped = rdy && (exp_q.size() != 0);
      if (popped) void'(exp_q.pop_front());
      if (cap && !m_halted) begin
        if (m_prev_vld && (pc == m_prev_pc)) nh = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back({m_seq, pc, alu});
        else if (m_drop < 255) m_drop++;
        m_seq      = m_seq + 8'd1;
        m_prev_pc  = pc;
        m_prev_vld = 1'b1;
      end
      if (!cap) m_prev_vld = 1'b0;
      if (nh) m_halted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, rdy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] halt_pcs[5];
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values, then three samples held back, then drained.
    cycle(1'b1, 16'd0, 16'd5, 1'b0, 1'b0);
    cycle(1'b1, 16'd2, 16'd6, 1'b0, 1'b0);
    cycle(1'b1, 16'd4, 16'd7, 1'b0, 1'b0);
    chk("basic_count3", 32'(count), 32'd3);
    idle(4, 1'b1);

    // Overflow: 20 distinct PCs into 16 slots.
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 16'(16'h100 + 2*i), 16'(16'hA000 + i), 1'b0, 1'b0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd4);
    idle(1, 1'b1);                                        // pop seq 0
    cycle(1'b1, 16'h200, 16'h1234, 1'b0, 1'b0);           // stored with seq 20
    // Full with simultaneous pop and sample: accepted, count stays 16.
    cycle(1'b1, 16'h202, 16'h5678, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count), 32'd16);
    chk("fullpop_drop", 32'(drop_cnt), 32'd4);
    idle(18, 1'b1);

    // Halt idiom: 0,2,4,4,4 keeps 0,2,4,4 and freezes seq at 4.
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    halt_pcs = '{16'd0, 16'd2, 16'd4, 16'd4, 16'd4};
    for (int i = 0; i < 5; i++) cycle(1'b1, halt_pcs[i], 16'(16'h50 + i), 1'b0, 1'b0);
    cycle(1'b1, 16'd8, 16'h99, 1'b0, 1'b0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", 32'(count), 32'd4);
    idle(6, 1'b1);

    // Capture gap between equal PCs: no halt, both kept.
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    cycle(1'b1, 16'd30, 16'd1, 1'b0, 1'b0);
    cycle(1'b0, 16'd30, 16'd2, 1'b0, 1'b0);
    cycle(1'b1, 16'd30, 16'd3, 1'b0, 1'b0);
    chk("gap_nohalt", 32'(halted), 32'd0);
    chk("gap_count", 32'(count), 32'd2);

    // Clear while halted with 5 records queued; next sample gets seq 0.
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(10 + 2*((i < 4) ? i : 3)), 16'(i), 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("clr_pre_halted", 32'(halted), 32'd1);
    chk("clr_pre_count", 32'(count), 32'd5);
    cycle(1'b1, 16'h77, 16'h77, 1'b1, 1'b1);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_halted", 32'(halted), 32'd0);
    cycle(1'b1, 16'h300, 16'h301, 1'b0, 1'b0);
    chk("clr_seq0", 32'(trc_seq), 32'd0);
    idle(2, 1'b1);

    // Random traffic with small PC range so halts and overflow both occur.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 16'(2 * $urandom_range(0, 5)),
            16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 40) == 0));

    // Async reset mid-drain: outputs return before any clock edge.
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'(16'h400 + 2*i), 16'(i), 1'b0, 1'b0);
    idle(2, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(trc_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_pc", 32'(trc_pc), 32'd0);
    chk("arst_alu", 32'(trc_alu), 32'd0);
    chk("arst_seq", 32'(trc_seq), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b1, 16'h500, 16'h501, 1'b0, 1'b0);
    idle(3, 1'b1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
